// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round sequencer.
package aes_pkg;

  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, HOLD} aes_ctrl_state_t;

  // Round count for a key length; 0 flags an illegal key length.
  function automatic int nr_of(input int k);
    case (k)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable saturating round counter with clear, enable and terminal flag at MAX.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int MAX = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld,
  input  logic [ROUND_W-1:0] ld_val,
  input  logic               en,
  output logic [ROUND_W-1:0] cnt,
  output logic               term
);

  assign term = (cnt == ROUND_W'(MAX));

  always_ff @(posedge clk) begin
    if (reset || clr)     cnt <= '0;
    else if (ld)          cnt <= ld_val;
    else if (en && !term) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: job handshake, key expander control, round strobes.
// Optional key-cache replay is enabled by defining AES_CTRL_KEYCACHE_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_key_new,
  output logic               exp_reset,
  output logic               exp_done,
  output logic               ld_en,
  output logic               rnd_en,
  output logic               rnd_last,
  output logic [ROUND_W-1:0] round_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int NR = nr_of(K);

  generate
    if (NR == 0) begin : g_bad_k
      $error("aes_round_ctrl: K must be 128, 192 or 256");
    end
  endgenerate

  aes_ctrl_state_t state_q, state_n;
  logic accept, hit, fresh, term, done_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_n = LOAD;
      LOAD:    state_n = ROUND;
      ROUND:   if (term) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  aes_round_cnt #(.MAX(NR)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_n == IDLE),
    .ld     (state_n == LOAD),
    .ld_val ('0),
    .en     (state_n == ROUND),
    .cnt    (round_idx),
    .term   (term)
  );

  assign accept = in_valid && (state_q == IDLE) && !reset;

`ifdef AES_CTRL_KEYCACHE_EN
  logic cache_valid;

  always_ff @(posedge clk) begin
    if (reset)                         cache_valid <= 1'b0;
    else if (state_q == ROUND && term) cache_valid <= 1'b1;
  end

  assign hit = cache_valid && !in_key_new;
`else
  logic unused_key_new;
  assign unused_key_new = in_key_new;
  assign hit = 1'b0;
`endif

  // A fresh job restarts expansion; a cache hit leaves the expander replaying.
  assign fresh = accept && !hit;

  always_ff @(posedge clk) begin
    if (reset)                         done_q <= 1'b0;
    else if (state_q == ROUND && term) done_q <= 1'b1;
    else if (fresh)                    done_q <= 1'b0;
  end

  assign in_ready  = (state_q == IDLE);
  assign exp_reset = reset || fresh;
  assign exp_done  = done_q && !fresh && !reset;
  assign ld_en     = (state_q == LOAD);
  assign rnd_en    = (state_q == ROUND);
  assign rnd_last  = (state_q == ROUND) && term;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: K=128 and K=256 instances, cycle-accurate timeline checks.
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] iv, ikn, ordy;
  logic [1:0] ir, er, ed, ld, re, rl, ov, bz;
  logic [1:0][3:0] ri;

  int n_chk = 0;
  int n_err = 0;

  aes_round_ctrl #(.K(128)) dut128 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_key_new(ikn[0]),
    .exp_reset(er[0]), .exp_done(ed[0]), .ld_en(ld[0]), .rnd_en(re[0]), .rnd_last(rl[0]),
    .round_idx(ri[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0]));

  aes_round_ctrl #(.K(256)) dut256 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_key_new(ikn[1]),
    .exp_reset(er[1]), .exp_done(ed[1]), .ld_en(ld[1]), .rnd_en(re[1]), .rnd_last(rl[1]),
    .round_idx(ri[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1]));

  // {in_ready, exp_reset, exp_done, ld_en, rnd_en, rnd_last, out_valid, busy, round_idx}
  function automatic logic [11:0] obs(input int s);
    return {ir[s], er[s], ed[s], ld[s], re[s], rl[s], ov[s], bz[s], ri[s]};
  endfunction

  // Expected outputs c cycles after the accept cycle.
  function automatic logic [11:0] expv(input int nr, input int c, input int hold, input bit hit);
    logic a_ir, a_er, a_ed, a_ld, a_re, a_rl, a_ov, a_bz;
    logic [3:0] idx;
    {a_ir, a_er, a_ed, a_ld, a_re, a_rl, a_ov, a_bz} = '0;
    idx = '0;
    if (c == 0) begin
      a_ir = 1'b1; a_er = !hit; a_ed = hit;
    end else if (c == 1) begin
      a_ld = 1'b1; a_bz = 1'b1; a_ed = hit;
    end else if (c <= nr + 1) begin
      a_re = 1'b1; a_bz = 1'b1; a_ed = hit; idx = 4'(c - 1); a_rl = (c == nr + 1);
    end else if (c <= nr + 2 + hold) begin
      a_ov = 1'b1; a_bz = 1'b1; a_ed = 1'b1; idx = 4'(nr);
    end else begin
      a_ir = 1'b1; a_ed = 1'b1;
    end
    return {a_ir, a_er, a_ed, a_ld, a_re, a_rl, a_ov, a_bz, idx};
  endfunction

  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job on instance s, in_valid also held during HOLD to prove it is ignored there.
  task automatic run_job(input int s, input int nr, input int hold, input bit keynew,
                         input bit hit, input string tag);
    for (int c = 0; c <= nr + 3 + hold; c++) begin
      iv[s]   = (c == 0) || (c >= nr + 2 && c <= nr + 2 + hold);
      ikn[s]  = keynew;
      ordy[s] = (c >= nr + 2 + hold);
      #4;
      chk($sformatf("%s c%0d", tag, c), obs(s), expv(nr, c, hold, hit));
      tick();
    end
    iv[s] = 1'b0;
  endtask

  int acc_cyc[$];
  bit saw_ov;

  initial begin
    reset = 1'b1; iv = '0; ikn = '0; ordy = '0;
    tick();
    #4 chk("in_reset", obs(0), 12'hC00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4 chk($sformatf("idle%0d", i), obs(0), 12'h800);
      tick();
    end

    run_job(0, 10, 0, 1'b1, 1'b0, "k128");
    run_job(1, 14, 0, 1'b1, 1'b0, "k256");
    run_job(0, 10, 7, 1'b1, 1'b0, "bp");

    // Abort in ROUND at round_idx 4.
    ordy[0] = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      iv[0] = (c == 0);
      if (c == 5) reset = 1'b1;
      #4;
      if (c == 5) chk("abort_mid", {8'h0, ri[0]}, 12'd4);
      if (c == 5) chk("abort_exp_reset", {11'h0, er[0]}, 12'd1);
      tick();
    end
    reset = 1'b0;
    #4 chk("after_abort", obs(0), 12'h800);
    tick();
    saw_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4 if (ov[0]) saw_ov = 1'b1;
      tick();
    end
    chk("no_out_after_abort", {11'h0, saw_ov}, 12'd0);
    run_job(0, 10, 0, 1'b1, 1'b0, "rerun");

    // Back-to-back accepts with in_valid and out_ready held high.
    iv[0] = 1'b1; ordy[0] = 1'b1;
    for (int c = 0; c <= 39; c++) begin
      #4 if (ir[0] && iv[0]) acc_cyc.push_back(c);
      tick();
    end
    iv[0] = 1'b0;
    chk("b2b_count", 12'(acc_cyc.size()), 12'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 12'(acc_cyc[i] - acc_cyc[i-1]), 12'd13);
    for (int i = 0; i < 14; i++) tick();

`ifdef AES_CTRL_KEYCACHE_EN
    run_job(0, 10, 0, 1'b1, 1'b0, "kc_new");
    run_job(0, 10, 0, 1'b0, 1'b1, "kc_hit");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_job(0, 10, 0, 1'b0, 1'b0, "kc_after_rst");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for one AES encryption core: accepts a block/key job on a valid/ready handshake and drives the key expander (`expand`) via its reset/done pins.
- Issues per-round strobes to the cipher round datapath and presents the result on a valid/ready output handshake.
- Sits between the bus-facing wrapper and the `expand` + round datapath pair; owns all round counting.

Parameters:
- K, 128, key length in bits; legal values 128/192/256, any other value is a compile-time error.
- NR, derived (10/12/14 for K=128/192/256), number of rounds; localparam, not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  job offered (block and key on datapath-side buses)
- in_ready  out  1  controller can accept a job
- in_key_new  in  1  job carries a new key; used only with the optional feature
- exp_reset  out  1  to expander reset; restarts key expansion
- exp_done  out  1  to expander done; high = expander replays cached round keys
- ld_en  out  1  datapath loads input block and applies AddRoundKey(round key 0)
- rnd_en  out  1  datapath performs one round this cycle
- rnd_last  out  1  current round is the final round (no MixColumns)
- round_idx  out  4  current round number, 0..NR
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- busy  out  1  job in flight (any state except IDLE)

Behaviour:
- States and transitions:
  - IDLE: in_ready=1. On in_valid go to LOAD.
  - LOAD: one cycle. ld_en=1, round_idx=0. Go to ROUND.
  - ROUND: rnd_en=1, round_idx increments 1..NR, one round per cycle. rnd_last=1 when round_idx==NR. After round NR go to HOLD.
  - HOLD: out_valid=1 until out_ready. On out_ready go to IDLE.
- Accept: a job is taken on the cycle in_valid & in_ready (IDLE only). There is no accept in HOLD; a new job waits for IDLE.
- Expander control:
  - exp_reset is a one-cycle pulse on the accept cycle.
  - exp_done=0 from accept through round NR.
  - exp_done rises on the cycle LOAD→... round NR completes and stays 1 in HOLD and IDLE, so the expander rotates cached keys.
  - Round key k is valid in the cycle round_idx==k.
- Latency: accept cycle = T. LOAD at T+1. Rounds at T+2..T+NR+1. out_valid first high at T+NR+2.
- Throughput: with out_ready tied high, one job per NR+3 cycles.
- Output rule: out_valid, once high, holds until out_ready. The datapath must keep ciphertext stable while out_valid is high.
- round_idx: 4-bit, saturates at NR, returns to 0 in IDLE. No wrap.
- Reset values: state=IDLE, in_ready=1 on the cycle after reset, exp_reset=1 during reset, exp_done=0, ld_en=rnd_en=rnd_last=0, round_idx=0, out_valid=0, busy=0.
- Reset mid-job: the job is aborted with no output. All outputs return to their reset values the next cycle, and the cache is marked invalid.
- in_valid & out_ready both high in HOLD: out_ready is handled; in_valid is ignored until IDLE.

Optional Feature:
- Macro: AES_CTRL_KEYCACHE_EN.
- Defined:
  - A 1-bit cache_valid register sets when a job completes round NR and clears on reset.
  - A job with in_key_new=0 and cache_valid=1 skips the exp_reset pulse and keeps exp_done=1 throughout, so the expander replays stored keys aligned to round_idx.
  - Latency is unchanged.
- Undefined: in_key_new is ignored; every job pulses exp_reset and re-expands.

Decomposition:
- Shared package aes_pkg holds:
  - state enum type aes_ctrl_state_t (IDLE, LOAD, ROUND, HOLD);
  - function nr_of(K);
  - constant ROUND_W=4.
- One sub-module: aes_round_cnt, a loadable saturating 4-bit counter with clear, enable and terminal flag (==NR).

Test Plan:
- K=128, single job with out_ready=1: in_valid at cycle 5 → exp_reset pulse at 5, ld_en at 6, rnd_en at 7..16, rnd_last only at 16, out_valid at 17, in_ready back at 18.
- K=256: round_idx steps 1..14, rnd_last at round 14, out_valid 16 cycles after accept.
- Backpressure: out_ready low for 7 cycles in HOLD → out_valid held 8 cycles, in_ready=0 throughout, no second accept.
- Reset asserted in ROUND at round_idx=4 → next cycle: all outputs at reset values, out_valid never asserts, next job runs a full sequence.
- Back-to-back jobs, in_valid held high with out_ready=1 → accepts spaced exactly NR+3 cycles apart.
- AES_CTRL_KEYCACHE_EN defined: job 1 with in_key_new=1, then job 2 with in_key_new=0 → job 2 has no exp_reset pulse and exp_done=1 throughout; a job with in_key_new=0 right after reset still pulses exp_reset.
